// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes the immediate and its format from an instruction
// word and queues {imm, fmt} in a small FIFO so decode can stall safely.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic [31:0]     i_inst,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_valid,
  input  logic            i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = XLEN + 3;
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);

  localparam logic [2:0] fmt_none  = 3'd0;
  localparam logic [2:0] fmt_i     = 3'd1;
  localparam logic [2:0] fmt_s     = 3'd2;
  localparam logic [2:0] fmt_b     = 3'd3;
  localparam logic [2:0] fmt_u     = 3'd4;
  localparam logic [2:0] fmt_j     = 3'd5;
  localparam logic [2:0] fmt_shamt = 3'd6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  assign opcode   = i_inst[6:0];
  assign funct3   = i_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Total decode of the immediate and its format; unknown opcodes give NONE/0.
  always_comb begin
    dec_imm = '0;
    dec_fmt = fmt_none;
    case (opcode)
      7'b0010011: begin
        if (is_shift) begin
          dec_fmt = fmt_shamt;
          if (XLEN == 64) dec_imm = {{(XLEN-6){1'b0}}, i_inst[25:20]};
          else            dec_imm = {{(XLEN-5){1'b0}}, i_inst[24:20]};
        end else begin
          dec_fmt = fmt_i;
          dec_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
        end
      end
      7'b0011011: begin
        // Word-sized ops only exist on the 64-bit datapath.
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = fmt_shamt;
            dec_imm = {{(XLEN-5){1'b0}}, i_inst[24:20]};
          end else begin
            dec_fmt = fmt_i;
            dec_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
          end
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = fmt_i;
        dec_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
      end
      7'b0100011: begin
        dec_fmt = fmt_s;
        dec_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = fmt_b;
        dec_imm = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                   i_inst[30:25], i_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_fmt = fmt_j;
        dec_imm = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                   i_inst[20], i_inst[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = fmt_u;
        dec_imm = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
      end
      default: begin
        dec_imm = '0;
        dec_fmt = fmt_none;
      end
    endcase
  end

  // Handshake status depends only on the registered occupancy.
  assign o_ready = (count_reg != full_cnt);
  assign o_valid = (count_reg != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem[wr_ptr_reg] <= {dec_imm, dec_fmt};
  end

  // Pointer and occupancy bookkeeping; flush beats any push or pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head entry is forced to zero whenever the queue is empty.
  assign head  = mem[rd_ptr_reg];
  assign o_imm = o_valid ? head[EW-1:3] : '0;
  assign o_fmt = o_valid ? head[2:0]    : 3'd0;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, buffered immediate generator for the decode path of the pipelined core.
- Accepts one instruction word per cycle over a valid/ready handshake and extracts and sign-extends its immediate to XLEN.
- Also classifies the immediate format.
- Results are queued in a DEPTH-entry FIFO so decode can stall without losing instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_flush  input  1  synchronous flush; empties the FIFO.
- i_inst  input  32  instruction word.
- i_valid  input  1  i_inst is valid this cycle.
- o_ready  output  1  block can accept an instruction this cycle.
- o_imm  output  XLEN  immediate of the head entry.
- o_fmt  output  3  format of the head entry: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- o_valid  output  1  head entry is valid.
- i_ready  input  1  downstream consumes the head entry when o_valid=1.

Behaviour:
- Reset (async, i_rst=1): read/write pointers and count = 0; o_valid=0; o_imm=0; o_fmt=0; o_ready=1 once reset deasserts.
- Accept (push) when i_valid && o_ready. Pop when o_valid && i_ready.
- o_ready = (count != DEPTH). o_valid = (count != 0). No combinational path from i_inst or i_valid to any output.
- Latency: an instruction accepted in cycle N appears at the head no earlier than cycle N+1. With an empty FIFO it appears exactly in N+1.
- Decoding is combinational on i_inst. Only the encoded {imm, fmt} is stored.
- The decode function is total: every opcode yields a defined value, and no latches are permitted.
- Decode table. sx() sign-extends from inst[31] to XLEN. zx() zero-extends.
  - 0010011 OP-IMM: if funct3 is 001 or 101, SHAMT with zx(inst[24:20]) for XLEN=32 and zx(inst[25:20]) for XLEN=64. Otherwise I with sx(inst[31:20]).
  - 0011011 OP-IMM-32, only when XLEN=64: shifts are SHAMT zx(inst[24:20]). Otherwise I sx(inst[31:20]). When XLEN=32 this opcode is NONE.
  - 0000011 LOAD: I sx(inst[31:20]).
  - 1100111 JALR: I sx(inst[31:20]).
  - 0100011 STORE: S sx({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH: B sx({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 1101111 JAL: J sx({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 0110111 LUI and 0010111 AUIPC: U sx({inst[31:12], 12'b0}). This equals the raw value for XLEN=32 and is sign-extended above bit 31 for XLEN=64.
  - Any other opcode: NONE, imm=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Simultaneous push and pop:
  - With 0 < count < DEPTH: count is unchanged and both pointers advance.
  - When full: o_ready=0, so only the pop occurs and there is no bypass.
  - When empty: only the push occurs.
- When empty: o_imm and o_fmt hold 0.
- i_flush:
  - Next cycle: count=0, pointers=0, o_valid=0.
  - Any push or pop in the flush cycle is discarded, including one with i_valid=1.
  - Flush has priority over push and pop.
- Reset mid-operation: all entries are lost immediately (asynchronously). The FIFO storage array need not be cleared.

Test Plan:
- Reset with i_valid=1 and i_inst=32'h00500093 held -> o_valid=0, o_imm=0, o_fmt=0. After deassert: o_ready=1, entry accepted, next cycle o_imm=5, o_fmt=1.
- XLEN=32 stream with i_ready=1: 32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000EF, 32'h12345037 -> one output per cycle:
  - 32'hFFFFFFFF, fmt 1
  - 32'hFFFFFFFC, fmt 2
  - 32'hFFFFFFFC, fmt 3
  - 32'hFFF00000, fmt 5
  - 32'h12345000, fmt 4
- XLEN=64 shift 32'h03F01093 (slli x1, x0, 63) -> imm 64'd63, fmt 6. Then 32'h800002B7 (lui) -> imm 64'hFFFFFFFF80000000, fmt 4.
- DEPTH=2, i_ready=0, three back-to-back pushes -> o_ready=0 after the second accept and the third is held off. Raise i_ready -> entries drained in order, o_ready=1 after the first pop.
- Full FIFO, i_flush=1 with i_valid=1 and i_ready=1 -> next cycle o_valid=0 and o_ready=1, with no stale entry emerging.
- R-type 32'h002081B3 -> o_fmt=0, o_imm=0, o_valid=1.
